// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between execute stage and data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [31:0]           Instr,
    input  logic [DATA_WIDTH-1:0] AluOut,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic                  MemWe,
    output logic [3:0]            MemBe,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic                  MemRspValid,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic                  LoadValid,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  StoreDone,
    output logic                  Busy,
    output logic                  Misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, sdata_q, sdata_d, ldata_q, ldata_d;
    logic [2:0]  f3_q, f3_d;
    logic        ld_q, ld_d, mis_q, mis_d;

    logic [2:0]  f3;
    logic        is_ld, is_st, unsup, mis;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ext;
    logic        unused_instr;

    assign unused_instr = ^{Instr[31:15], Instr[11:7]};
    assign f3    = Instr[14:12];
    assign is_ld = Instr[6:0] == OP_LOAD;
    assign is_st = Instr[6:0] == OP_STORE;
    assign unsup = is_ld ? (f3 == 3'd3 || f3[2:1] == 2'b11) : (f3 >= 3'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = !unsup && ((f3[1:0] == 2'b01 && AluOut[0]) || (f3[1:0] == 2'b10 && AluOut[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Halfwords select on addr[1] only; in trap mode addr[0] is already known clear.
    assign rb  = MemRData[{addr_q[1:0], 3'b000} +: 8];
    assign rh  = addr_q[1] ? MemRData[31:16] : MemRData[15:0];
    assign ext = f3_q == 3'd0 ? {{24{rb[7]}}, rb} :
                 f3_q == 3'd1 ? {{16{rh[15]}}, rh} :
                 f3_q == 3'd4 ? {24'd0, rb} :
                 f3_q == 3'd5 ? {16'd0, rh} : MemRData;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
            ldata_q <= '0;
            f3_q    <= '0;
            ld_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ldata_q <= ldata_d;
            f3_q    <= f3_d;
            ld_q    <= ld_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ldata_d = ldata_q;
        f3_d    = f3_q;
        ld_d    = ld_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (ReqValid && (is_ld || is_st)) begin
                addr_d  = AluOut;
                sdata_d = StoreData;
                f3_d    = f3;
                ld_d    = is_ld;
                mis_d   = mis;
                // Unsupported and trapped accesses skip memory and report straight from RESP.
                state_d = (unsup || mis) ? RESP : REQ;
                if (is_ld && unsup) ldata_d = '0;
            end
            REQ:  if (MemReqReady) state_d = ld_q ? WAIT : IDLE;
            WAIT: if (MemRspValid) begin
                ldata_d = ext;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ReqReady    = state_q == IDLE;
    assign Busy        = state_q != IDLE;
    assign MemReqValid = state_q == REQ;
    assign MemWe       = MemReqValid && !ld_q;
    assign MemAddr     = MemReqValid ? {addr_q[31:2], 2'b00} : '0;
    assign MemBe       = !MemReqValid ? 4'b0000 :
                         ld_q ? 4'b1111 :
                         f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                         f3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign MemWData    = !MemWe ? '0 :
                         f3_q[1:0] == 2'b00 ? {4{sdata_q[7:0]}} :
                         f3_q[1:0] == 2'b01 ? {2{sdata_q[15:0]}} : sdata_q;
    assign LoadValid   = state_q == RESP && ld_q && !mis_q;
    assign LoadData    = ldata_q;
    assign StoreDone   = (MemReqValid && MemReqReady && !ld_q) || (state_q == RESP && !ld_q && !mis_q);
`ifdef LSU_MISALIGN_TRAP_EN
    assign Misaligned  = state_q == RESP && mis_q;
`else
    assign Misaligned  = 1'b0;
`endif
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data and address width; only 32 is supported.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port ReqValid, input, 1 bit; execute stage presents a load or store.
REQ-005 SHALL have port ReqReady, output, 1 bit; the unit can accept a request this cycle.
REQ-006 SHALL have port Instr, input, 32 bits; the instruction word; only opcode LOAD or STORE and Funct3 [14:12] are used.
REQ-007 SHALL have port AluOut, input, 32 bits; the effective address from the ALU.
REQ-008 SHALL have port StoreData, input, 32 bits; the rs2 value.
REQ-009 SHALL have ports MemReqValid (output, 1), MemReqReady (input, 1), MemAddr (output, 32), MemWe (output, 1), MemBe (output, 4) and MemWData (output, 32), forming the data-memory request channel.
REQ-010 SHALL have ports MemRspValid (input, 1) and MemRData (input, 32), forming the memory read response.
REQ-011 SHALL have ports LoadValid (output, 1) and LoadData (output, 32); the extended load result for writeback.
REQ-012 SHALL have ports StoreDone (output, 1), Busy (output, 1) and Misaligned (output, 1).

Function
REQ-013 SHALL implement a four-state FSM with states IDLE, REQ, WAIT, RESP.
- IDLE: ReqReady=1. If ReqValid is high and the opcode is LOAD or STORE, capture address, Funct3, StoreData and the load/store flag, then go to REQ.
- REQ: MemReqValid=1. On MemReqReady, a store goes to IDLE with StoreDone pulsed in that cycle; a load goes to WAIT.
- WAIT: on MemRspValid, register the extended data and go to RESP.
- RESP: LoadValid=1 for exactly one cycle with LoadData valid, then go to IDLE.
REQ-014 SHALL hold ReqReady=0 outside IDLE; Busy SHALL equal NOT IDLE.
REQ-015 SHALL hold MemAddr, MemWe, MemBe and MemWData stable while MemReqValid is high and MemReqReady is low.
REQ-016 SHALL drive MemAddr as {addr[31:2],2'b00} and MemWe=1 for stores only.
REQ-017 SHALL generate MemBe as follows: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}; SW = 4'b1111; loads = 4'b1111.
REQ-018 SHALL generate MemWData as follows: SB = {4{data[7:0]}}; SH = {2{data[15:0]}}; SW = data.
REQ-019 SHALL extract load data from MemRData using addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
REQ-020 SHALL give a load a latency of 1 cycle from acceptance to MemReqValid, plus zero or more stall cycles, plus 1 cycle from MemRspValid to LoadValid.
REQ-021 SHALL ignore MemRspValid in IDLE, REQ and RESP.
REQ-022 SHALL treat unsupported Funct3 values (load 3/6/7, store 3-7) as follows: no memory request is issued; a load pulses LoadValid with LoadData=0 one cycle after acceptance; a store pulses StoreDone one cycle after acceptance.
REQ-023 SHALL hold LoadData at its last value when LoadValid is low.

Reset
REQ-024 SHALL, on Rst high at a clock edge, enter IDLE and clear all outputs to 0 except ReqReady. Any in-flight request is abandoned, and a later MemRspValid is ignored.
REQ-025 SHALL drive ReqReady=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL support macro LSU_MISALIGN_TRAP_EN. When it is defined, a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) access issues no memory request. For such an access, Misaligned SHALL pulse one cycle after acceptance, no LoadValid or StoreDone SHALL be produced, and the FSM SHALL return to IDLE.
REQ-027 SHALL, when LSU_MISALIGN_TRAP_EN is undefined, tie Misaligned to 0. In that mode, halfwords SHALL use addr[1] only and words SHALL ignore addr[1:0], with no trap.

Verification
REQ-028 SHALL cover SB: AluOut=0x1003, StoreData=0xA5 -> MemAddr=0x1000, MemBe=4'b1000, MemWData=0xA5A5A5A5, MemWe=1, StoreDone pulses once.
REQ-029 SHALL cover LB: AluOut=0x2002, MemRData=0x00800000 -> LoadData=0xFFFFFF80; LBU with the same inputs -> LoadData=0x00000080.
REQ-030 SHALL cover a stalled request: a load with MemReqReady low for 3 cycles -> MemReqValid is held and MemAddr is stable, ReqReady=0, and LoadValid appears one cycle after MemRspValid.
REQ-031 SHALL cover misalignment: LW at 0x3001 with the macro defined -> no MemReqValid and one Misaligned pulse; with the macro undefined -> MemAddr=0x3000, MemBe=4'b1111.
REQ-032 SHALL cover reset in WAIT: Rst is asserted, then MemRspValid arrives -> no LoadValid and ReqReady=1.
REQ-033 SHALL cover back-to-back requests: SW is accepted while ReqValid stays high -> the second request is accepted only on the cycle after StoreDone.
